mac_dot_unit: RTL and testbench

Parametrised, multi-lane, signed fixed-point multiply-accumulate engine for the convolution datapath. Each accepted beat multiplies LANES pixel/weight pairs, sums the products and adds them into a wide saturating accumulator. After a programmed number of beats it rescales the sum by FRAC bits, saturates it to DATA_W and presents it on a valid/ready output. It replaces the single-lane, free-running MAC with a framed, handshaked, overflow-safe unit.

---
 rtl/mac_dot_unit.sv | 177 +++++++++++++++++
 tb/tb_mac_dot_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_unit.sv
// Framed multi-lane signed fixed-point MAC: LANES products per beat into a saturating
// ACC_W accumulator, then rescaled by FRAC and saturated to DATA_W on a valid/ready output.
module mac_dot_unit #(
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] pixel,
    input  logic [LANES*DATA_W-1:0] weight,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       result,
    output logic                    busy,
    output logic                    overflow
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_t;

    state_t                   state_q;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         cnt_q;
    logic                     drain_q;
    logic                     prod_vld_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic                     ovf_q;
    logic [DATA_W-1:0]        result_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [PROD_W-1:0] prod_q [LANES];

    logic                     beat_s;
    logic                     last_beat_s;
    logic signed [SUM_W-1:0]  lane_sum_s;
    logic signed [ACC_W:0]    acc_wide_s;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  shifted_s;
    logic                     acc_clip_s;
    logic                     res_clip_s;
    logic [DATA_W-1:0]        result_d;

    // in_ready_q is only ever high in ACCUM, so it alone qualifies a beat
    assign beat_s      = in_valid && in_ready_q;
    assign last_beat_s = beat_s && ((cnt_q + LEN_W'(1)) == len_q);

    // Lane sum plus accumulator; overflow shows up as disagreeing top two bits
    always_comb begin
        lane_sum_s = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum_s = lane_sum_s + SUM_W'(prod_q[l]);
        end
        acc_wide_s = (ACC_W+1)'(acc_q) + (ACC_W+1)'(lane_sum_s);
        if (acc_wide_s[ACC_W] != acc_wide_s[ACC_W-1]) begin
            acc_clip_s = 1'b1;
            acc_d      = {acc_wide_s[ACC_W], {(ACC_W-1){~acc_wide_s[ACC_W]}}};
        end else begin
            acc_clip_s = 1'b0;
            acc_d      = acc_wide_s[ACC_W-1:0];
        end
    end

    // Rescale with floor semantics, then saturate to the output width
    always_comb begin
        shifted_s = acc_q >>> FRAC;
        if (shifted_s[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){shifted_s[ACC_W-1]}}) begin
            res_clip_s = 1'b1;
            result_d   = {shifted_s[ACC_W-1], {(DATA_W-1){~shifted_s[ACC_W-1]}}};
        end else begin
            res_clip_s = 1'b0;
            result_d   = shifted_s[DATA_W-1:0];
        end
    end

    // Control FSM with the two-stage datapath and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            prod_vld_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            acc_q       <= '0;
            for (int l = 0; l < LANES; l++) begin
                prod_q[l] <= '0;
            end
        end else begin
            prod_vld_q <= beat_s;
            if (beat_s) begin
                for (int l = 0; l < LANES; l++) begin
                    prod_q[l] <= PROD_W'($signed(pixel[l*DATA_W +: DATA_W]))
                               * PROD_W'($signed(weight[l*DATA_W +: DATA_W]));
                end
            end
            if (prod_vld_q) begin
                acc_q <= acc_d;
                if (acc_clip_s) begin
                    ovf_q <= 1'b1;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        len_q   <= len;
                        drain_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (len != '0) begin
                            state_q    <= S_ACCUM;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_ACCUM: begin
                    if (beat_s) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                    end
                    if (last_beat_s) begin
                        in_ready_q <= 1'b0;
                        drain_q    <= 1'b0;
                        state_q    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!drain_q) begin
                        drain_q <= 1'b1;
                    end else begin
                        result_q    <= result_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                        if (res_clip_s) begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_dot_unit.sv
// Scoreboard bench for mac_dot_unit: directed and random jobs, expected {overflow,result}
// queued at issue time and compared by an independent output monitor.
module tb_mac_dot_unit;
    localparam int DATA_W = 16;
    localparam int FRAC   = 8;
    localparam int LANES  = 4;
    localparam int ACC_W  = 40;
    localparam int LEN_W  = 10;
    localparam longint ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;

    logic                    clk = 1'b0;
    logic                    reset, start, in_valid, out_ready;
    logic [LEN_W-1:0]        len;
    logic [LANES*DATA_W-1:0] pixel, weight;
    logic                    in_ready, out_valid, busy, overflow;
    logic [DATA_W-1:0]       result;

    int total = 0;
    int bad   = 0;
    logic [DATA_W:0]         exp_q [$];
    logic [LANES*DATA_W-1:0] px_q [$];
    logic [LANES*DATA_W-1:0] wt_q [$];

    mac_dot_unit #(.DATA_W(DATA_W), .FRAC(FRAC), .LANES(LANES), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(in_ready), .pixel(pixel), .weight(weight), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Dot product over the queued beats, accumulator clamped per beat, then floor-rescaled
    function automatic logic [DATA_W:0] model(input int n);
        longint acc, s, q;
        logic   o;
        acc = 0;
        o   = 1'b0;
        for (int b = 0; b < n; b++) begin
            s = 0;
            for (int l = 0; l < LANES; l++) begin
                s += longint'($signed(px_q[b][l*DATA_W +: DATA_W]))
                   * longint'($signed(wt_q[b][l*DATA_W +: DATA_W]));
            end
            acc += s;
            if (acc > ACC_MAX) begin
                acc = ACC_MAX;
                o   = 1'b1;
            end else if (acc < -ACC_MAX - 1) begin
                acc = -ACC_MAX - 1;
                o   = 1'b1;
            end
        end
        q = acc >>> FRAC;
        if (q > 32767) return {1'b1, 16'h7FFF};
        if (q < -32768) return {1'b1, 16'h8000};
        return {o, q[15:0]};
    endfunction

    task automatic fill(input int n, input logic [15:0] p, input logic [15:0] w);
        px_q.delete();
        wt_q.delete();
        for (int b = 0; b < n; b++) begin
            px_q.push_back({LANES{p}});
            wt_q.push_back({LANES{w}});
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // stall<0: random gaps; noise: start pulsed during ACCUM and on the OUT handshake edge
    task automatic run_job(input int n, input int stall, input int bp, input bit noise,
                           input bit use_const, input logic [DATA_W:0] cexp);
        int          lat;
        int          k;
        logic [15:0] r0;
        logic        o0;
        exp_q.push_back(use_const ? cexp : model(n));
        start = 1'b1;
        len   = LEN_W'(n);
        step();
        start = 1'b0;
        for (int b = 0; b < n; b++) begin
            k = (stall < 0) ? int'($urandom_range(0, 2)) : ((b == 0) ? 0 : stall);
            for (int s = 0; s < k; s++) begin
                in_valid = 1'b0;
                pixel    = {$urandom, $urandom};
                weight   = {$urandom, $urandom};
                start    = noise;
                step();
            end
            check("in_ready_beat", in_ready, 1);
            in_valid = 1'b1;
            pixel    = px_q[b];
            weight   = wt_q[b];
            start    = noise;
            len      = 10'd7;
            step();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (n > 0) check("in_ready_drop", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        check("latency", lat, 2);
        if (!out_valid) begin
            void'(exp_q.pop_back());
            reset_dut();
            return;
        end
        r0 = result;
        o0 = overflow;
        out_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            step();
            check("hold_valid", out_valid, 1);
            check("hold_result", result, r0);
            check("hold_ovf", overflow, o0);
        end
        out_ready = 1'b1;
        start     = noise;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        check("busy_after", busy, 0);
        check("valid_after", out_valid, 0);
        step();
    endtask

    // Monitor: compare every transferred result against the oldest expectation
    initial begin
        logic [DATA_W:0] e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got %0h expected none", {overflow, result});
                end else begin
                    e = exp_q.pop_front();
                    check("result", {overflow, result}, e);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        len = '0; pixel = '0; weight = '0;
        step(); step(); step();
        reset = 1'b0;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);

        fill(1, 16'h0100, 16'h0200); run_job(1, 0, 0, 1'b0, 1'b1, {1'b0, 16'h0800});
        fill(3, 16'h0080, 16'h0100); run_job(3, 2, 0, 1'b0, 1'b1, {1'b0, 16'h0600});
        fill(1, 16'hFF00, 16'h0100); run_job(1, 0, 0, 1'b0, 1'b1, {1'b0, 16'hFC00});
        fill(4, 16'h7FFF, 16'h7FFF); run_job(4, 0, 5, 1'b0, 1'b1, {1'b1, 16'h7FFF});
        fill(4, 16'h8001, 16'h7FFF); run_job(4, 0, 1, 1'b0, 1'b1, {1'b1, 16'h8000});
        fill(0, 16'h0000, 16'h0000); run_job(0, 0, 0, 1'b0, 1'b1, {1'b0, 16'h0000});
        fill(2, 16'h0100, 16'h0100); run_job(2, 1, 2, 1'b1, 1'b1, {1'b0, 16'h0800});

        // Abort a 5-beat job after two large beats
        start = 1'b1; len = 10'd5; step(); start = 1'b0;
        in_valid = 1'b1; pixel = {LANES{16'h7FFF}}; weight = {LANES{16'h7FFF}};
        step(); step();
        reset = 1'b1;
        step();
        check("mid_in_ready", in_ready, 0);
        check("mid_out_valid", out_valid, 0);
        check("mid_result", result, 0);
        check("mid_busy", busy, 0);
        check("mid_overflow", overflow, 0);
        reset = 1'b0; in_valid = 1'b0;
        step();
        fill(1, 16'h0100, 16'h0300); run_job(1, 0, 0, 1'b0, 1'b1, {1'b0, 16'h0C00});

        for (int j = 0; j < 12; j++) begin
            int n;
            bit big;
            n   = int'($urandom_range(1, 6));
            big = 1'($urandom_range(0, 1));
            px_q.delete();
            wt_q.delete();
            for (int b = 0; b < n; b++) begin
                if (big) begin
                    pixel  = {$urandom, $urandom};
                    weight = {$urandom, $urandom};
                end else begin
                    for (int l = 0; l < LANES; l++) begin
                        v = 16'($urandom_range(0, 1023)) - 16'd512;
                        pixel[l*DATA_W +: DATA_W] = v;
                        v = 16'($urandom_range(0, 1023)) - 16'd512;
                        weight[l*DATA_W +: DATA_W] = v;
                    end
                end
                px_q.push_back(pixel);
                wt_q.push_back(weight);
            end
            run_job(n, -1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, '0);
        end

        step();
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
